// File: rtl/uart_recv_frame_if.sv
// Serial input and frame-level outputs of the UART frame receiver.
interface uart_recv_frame_if #(
    parameter int W = 64
);
    logic         uart_rxd;
    logic         uart_done;
    logic [W-1:0] uart_data;
    logic         frame_err;
    logic         timeout_err;
    logic         busy;

    modport master (
        input  uart_rxd,
        output uart_done,
        output uart_data,
        output frame_err,
        output timeout_err,
        output busy
    );

    modport slave (
        output uart_rxd,
        input  uart_done,
        input  uart_data,
        input  frame_err,
        input  timeout_err,
        input  busy
    );
endinterface

// File: rtl/uart_recv_frame.sv
// 8N1 UART receiver assembling NUM_BYTES bytes into one wide word,
// with glitch rejection, stop-bit check and inter-byte timeout.
module uart_recv_frame #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int UART_BPS     = 115200,
    parameter int NUM_BYTES    = 8,
    parameter int MSB_FIRST    = 1,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    uart_recv_frame_if.master bus
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF    = BPS_CNT / 2;
    localparam int W       = 8 * NUM_BYTES;
    localparam int TMO     = TIMEOUT_BITS * BPS_CNT;
    localparam int CW      = $clog2(BPS_CNT);
    localparam int TW      = $clog2(TMO);
    localparam int BW      = $clog2(NUM_BYTES + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BPS_M1  = CW'(BPS_CNT - 1);
    localparam logic [TW-1:0] TMO_M1  = TW'(TMO - 1);
    localparam logic [BW-1:0] LAST_B  = BW'(NUM_BYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic [W-1:0]  frame_q, frame_d;
    logic [W-1:0]  data_q, data_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic          terr_q, terr_d;
    logic          start;
    logic [W-1:0]  frame_n;

    assign start = rx_prev_q & ~rx_sync_q;

    // shifts are used instead of slices so NUM_BYTES=1 stays legal
    always_comb begin
        if (MSB_FIRST != 0) begin
            frame_n = (frame_q << 8) | W'(shift_q);
        end else begin
            frame_n = (frame_q >> 8) | (W'(shift_q) << (W - 8));
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = '0;
        frame_d    = frame_q;
        data_d     = data_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        terr_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (byte_cnt_q != '0) begin
                    if (idle_cnt_q == TMO_M1) begin
                        terr_d     = 1'b1;
                        byte_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TW'(1);
                    end
                end
                // a start coinciding with timeout still begins a new frame
                if (start) begin
                    state_d    = S_START;
                    clk_cnt_d  = '0;
                    idle_cnt_d = '0;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    if (!rx_sync_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == BPS_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt_q == BPS_M1) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (rx_sync_q) begin
                        frame_d = frame_n;
                        if (byte_cnt_q == LAST_B) begin
                            data_d     = frame_n;
                            done_d     = 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BW'(1);
                        end
                    end else begin
                        ferr_d     = 1'b1;
                        byte_cnt_d = '0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            frame_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= bus.uart_rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            frame_q    <= frame_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            terr_q     <= terr_d;
        end
    end

    assign bus.uart_done   = done_q;
    assign bus.uart_data   = data_q;
    assign bus.frame_err   = ferr_q;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = (state_q != S_IDLE) || (byte_cnt_q != '0);
endmodule

// File: tb/tb_uart_recv_frame.sv
// Bench for uart_recv_frame: MSB-first, LSB-first and single-byte
// receivers share one RX line and are checked against a byte-level model.
module tb_uart_recv_frame;
    localparam int CLK_FREQ = 1_600_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int HALF     = BPS / 2;
    localparam int TO_BITS  = 20;
    localparam int LAT      = 3 + HALF + 9 * BPS + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_recv_frame_if #(.W(64)) b0 ();
    uart_recv_frame_if #(.W(64)) b1 ();
    uart_recv_frame_if #(.W(8))  b2 ();
    assign b0.uart_rxd = rxd;
    assign b1.uart_rxd = rxd;
    assign b2.uart_rxd = rxd;

    uart_recv_frame #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .NUM_BYTES(8),
        .MSB_FIRST(1), .TIMEOUT_BITS(TO_BITS)
    ) u0 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b0));
    uart_recv_frame #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .NUM_BYTES(8),
        .MSB_FIRST(0), .TIMEOUT_BITS(TO_BITS)
    ) u1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b1));
    uart_recv_frame #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .NUM_BYTES(1),
        .MSB_FIRST(1), .TIMEOUT_BITS(TO_BITS)
    ) u2 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(b2));

    int a_done0 = 0, a_ferr0 = 0, a_terr0 = 0, a_wide0 = 0, a_dcyc0 = 0;
    int a_done1 = 0, a_ferr1 = 0, a_terr1 = 0, a_wide1 = 0;
    int a_done2 = 0, a_ferr2 = 0, a_terr2 = 0, a_wide2 = 0;
    logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;

    always @(negedge clk) begin
        if (b0.uart_done) begin a_done0++; a_dcyc0 = cyc; end
        if (b0.uart_done && p0) a_wide0++;
        if (b0.frame_err) a_ferr0++;
        if (b0.timeout_err) a_terr0++;
        p0 = b0.uart_done;
    end
    always @(negedge clk) begin
        if (b1.uart_done) a_done1++;
        if (b1.uart_done && p1) a_wide1++;
        if (b1.frame_err) a_ferr1++;
        if (b1.timeout_err) a_terr1++;
        p1 = b1.uart_done;
    end
    always @(negedge clk) begin
        if (b2.uart_done) a_done2++;
        if (b2.uart_done && p2) a_wide2++;
        if (b2.frame_err) a_ferr2++;
        if (b2.timeout_err) a_terr2++;
        p2 = b2.uart_done;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte-level reference model: per receiver, the list of bytes held
    logic [7:0]  m_buf [3][16];
    int          m_cnt [3];
    int          e_done [3];
    int          e_ferr [3];
    int          e_terr [3];
    logic [63:0] e_data [3];

    function automatic int nbk(input int k);
        return (k == 2) ? 1 : 8;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 0;
            e_data[k] = '0;
        end
    endtask

    task automatic m_byte(input logic [7:0] b, input bit ok);
        logic [63:0] w;
        for (int k = 0; k < 3; k++) begin
            if (!ok) begin
                e_ferr[k]++;
                m_cnt[k] = 0;
            end else begin
                m_buf[k][m_cnt[k]] = b;
                m_cnt[k]++;
                if (m_cnt[k] == nbk(k)) begin
                    w = '0;
                    for (int i = 0; i < nbk(k); i++) begin
                        if (k != 1) w[8*(nbk(k)-1-i) +: 8] = m_buf[k][i];
                        else        w[8*i +: 8] = m_buf[k][i];
                    end
                    e_data[k] = w;
                    e_done[k]++;
                    m_cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic m_idle(input int bits);
        for (int k = 0; k < 3; k++) begin
            if (m_cnt[k] != 0 && bits >= TO_BITS) begin
                e_terr[k]++;
                m_cnt[k] = 0;
            end
        end
    endtask

    int t_start = 0;

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BPS) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BPS) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(ok);
        if (!ok) drive_bit(1'b1);
        m_byte(b, ok);
    endtask

    task automatic run_entry(input logic [63:0] by, input int nb,
                             input int bad, input int gap, input int trail);
        for (int i = 0; i < nb; i++) begin
            if (i > 0) begin
                m_idle(gap);
                idle_bits(gap);
            end
            send_byte(by[63-8*i -: 8], i != bad);
        end
        m_idle(trail);
        idle_bits(trail);
    endtask

    task automatic check_model(input string tag);
        int ad [3];
        int af [3];
        int at [3];
        logic [63:0] dd [3];
        logic        bz [3];
        ad = '{a_done0, a_done1, a_done2};
        af = '{a_ferr0, a_ferr1, a_ferr2};
        at = '{a_terr0, a_terr1, a_terr2};
        dd = '{b0.uart_data, b1.uart_data, 64'(b2.uart_data)};
        bz = '{b0.busy, b1.busy, b2.busy};
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s dut%0d done", tag, k), 64'(ad[k]), 64'(e_done[k]));
            chk($sformatf("%s dut%0d ferr", tag, k), 64'(af[k]), 64'(e_ferr[k]));
            chk($sformatf("%s dut%0d terr", tag, k), 64'(at[k]), 64'(e_terr[k]));
            chk($sformatf("%s dut%0d data", tag, k), dd[k], e_data[k]);
            chk($sformatf("%s dut%0d busy", tag, k), 64'(bz[k]),
                64'(m_cnt[k] != 0));
        end
    endtask

    typedef struct {
        logic [63:0] bytes;
        int          nb;
        int          bad;
        int          gap;
        int          trail;
        logic [63:0] x_msb;
        logic [63:0] x_lsb;
        int          x_done;
        int          x_ferr;
        int          x_terr;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int d0, f0, t0;
        int lat;
        logic [63:0] rb;
        int rn, rbad, rgap, rtrail;

        for (int k = 0; k < 3; k++) begin
            e_done[k] = 0; e_ferr[k] = 0; e_terr[k] = 0;
        end
        m_reset();

        tbl[0] = '{64'h0102030405060708, 8, -1, 0, 2,
                   64'h0102030405060708, 64'h0807060504030201, 1, 0, 0};
        tbl[1] = '{64'h1122330000000000, 3, 2, 0, 2,
                   64'h0102030405060708, 64'h0807060504030201, 0, 1, 0};
        tbl[2] = '{64'hAAAAAAAAAAAAAAAA, 8, -1, 0, 2,
                   64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 1, 0, 0};
        tbl[3] = '{64'hC1C2C30000000000, 3, -1, 1, 25,
                   64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 0, 0, 1};
        tbl[4] = '{64'h1122334455667788, 8, -1, 0, 2,
                   64'h1122334455667788, 64'h8877665544332211, 1, 0, 0};

        repeat (4) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;
        idle_bits(2);
        check_model("post_reset");

        for (int v = 0; v < 5; v++) begin
            d0 = a_done0; f0 = a_ferr0; t0 = a_terr0;
            run_entry(tbl[v].bytes, tbl[v].nb, tbl[v].bad,
                      tbl[v].gap, tbl[v].trail);
            chk($sformatf("vec%0d done", v), 64'(a_done0 - d0), 64'(tbl[v].x_done));
            chk($sformatf("vec%0d ferr", v), 64'(a_ferr0 - f0), 64'(tbl[v].x_ferr));
            chk($sformatf("vec%0d terr", v), 64'(a_terr0 - t0), 64'(tbl[v].x_terr));
            chk($sformatf("vec%0d msb", v), b0.uart_data, tbl[v].x_msb);
            chk($sformatf("vec%0d lsb", v), b1.uart_data, tbl[v].x_lsb);
            check_model($sformatf("vec%0d", v));
            if (v == 0) begin
                lat = a_dcyc0 - t_start;
                n_tests++;
                if (lat < LAT - 1 || lat > LAT + 1) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles, expected %0d +-1", lat, LAT);
                end
            end
        end

        // short low pulse on an idle line
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("glitch busy_start", 64'(b0.busy), 64'd1);
        @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("glitch busy0", 64'(b0.busy), 64'd0);
        chk("glitch busy1", 64'(b1.busy), 64'd0);
        chk("glitch busy2", 64'(b2.busy), 64'd0);
        idle_bits(2);
        check_model("glitch");

        // reset asserted in the middle of byte 5
        run_entry(64'h3C3C3C3C00000000, 4, -1, 0, 0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 1'b0;
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst data0", b0.uart_data, 64'd0);
        chk("rst data1", b1.uart_data, 64'd0);
        chk("rst data2", 64'(b2.uart_data), 64'd0);
        chk("rst busy0", 64'(b0.busy), 64'd0);
        chk("rst done0", 64'(b0.uart_done), 64'd0);
        m_reset();
        rst_n = 1'b1;
        idle_bits(2);
        d0 = a_done0;
        run_entry(64'h5A5A5A5A5A5A5A5A, 8, -1, 0, 2);
        chk("rst frame done", 64'(a_done0 - d0), 64'd1);
        chk("rst frame data", b0.uart_data, 64'h5A5A5A5A5A5A5A5A);
        check_model("rst_frame");

        for (int r = 0; r < 10; r++) begin
            rb = {$urandom, $urandom};
            rn = $urandom_range(1, 8);
            rbad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
            rgap = $urandom_range(0, 3);
            rtrail = ($urandom_range(0, 2) == 0 || r == 9) ? 25 : 2;
            run_entry(rb, rn, rbad, rgap, rtrail);
            check_model($sformatf("rand%0d", r));
        end

        chk("done_width", 64'(a_wide0 + a_wide1 + a_wide2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
